// File: rtl/pe_pkg.sv
// Shared widths and saturation bounds for the weight-stationary PE.
// Saturation bounds are returned as bit patterns, valid for widths up to 64.
package pe_pkg;
  localparam int PE_DATA_WIDTH = 8;
  localparam int PE_ACC_WIDTH  = 2*PE_DATA_WIDTH + 4;

  // Most positive value for the given width and signedness.
  function automatic logic [63:0] sat_max(input int width, input bit sgn);
    return sgn ? (64'd1 << (width-1)) - 64'd1 : (64'd1 << width) - 64'd1;
  endfunction

  // Most negative value, as a two's-complement pattern 10..0.
  function automatic logic [63:0] sat_min(input int width, input bit sgn);
    return sgn ? (64'd1 << (width-1)) : 64'd0;
  endfunction
endpackage

// File: rtl/pe_mac.sv
// Combinational extend-multiply-add for ws_pe_dbuf.
// PE_SATURATE_EN selects clamping instead of modulo wraparound.
module pe_mac import pe_pkg::*; #(
  parameter int DATA_WIDTH = PE_DATA_WIDTH,
  parameter int ACC_WIDTH  = PE_ACC_WIDTH,
  parameter int SIGNED     = 1
) (
  input  logic [DATA_WIDTH-1:0] fmap,
  input  logic [DATA_WIDTH-1:0] weight,
  input  logic [ACC_WIDTH-1:0]  psum,
  output logic [ACC_WIDTH-1:0]  sum
);
  localparam int PW = 2*DATA_WIDTH;

  logic [PW-1:0]        prod;
  logic [ACC_WIDTH-1:0] prod_ext;

  generate
    if (SIGNED != 0) begin : g_sgn
      logic signed [PW-1:0] fs, ws;
      assign fs       = PW'($signed(fmap));
      assign ws       = PW'($signed(weight));
      assign prod     = fs * ws;
      assign prod_ext = ACC_WIDTH'($signed(prod));
    end else begin : g_uns
      assign prod     = PW'(fmap) * PW'(weight);
      assign prod_ext = ACC_WIDTH'(prod);
    end
  endgenerate

`ifdef PE_SATURATE_EN
  localparam logic [ACC_WIDTH-1:0] SMAX = ACC_WIDTH'(sat_max(ACC_WIDTH, SIGNED != 0));
  logic [ACC_WIDTH:0] wide;

  generate
    if (SIGNED != 0) begin : g_sat_s
      localparam logic [ACC_WIDTH-1:0] SMIN = ACC_WIDTH'(sat_min(ACC_WIDTH, 1'b1));
      // Signed overflow shows up as the guard bit disagreeing with the MSB.
      assign wide = {psum[ACC_WIDTH-1], psum} + {prod_ext[ACC_WIDTH-1], prod_ext};
      assign sum  = (wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1]) ?
                    (wide[ACC_WIDTH] ? SMIN : SMAX) : wide[ACC_WIDTH-1:0];
    end else begin : g_sat_u
      assign wide = {1'b0, psum} + {1'b0, prod_ext};
      assign sum  = wide[ACC_WIDTH] ? SMAX : wide[ACC_WIDTH-1:0];
    end
  endgenerate
`else
  assign sum = psum + prod_ext;
`endif
endmodule

// File: rtl/ws_pe_dbuf.sv
// Weight-stationary PE with shadow/active weight double buffer; one pipeline stage.
// Optional accumulator clamping via PE_SATURATE_EN (see pe_mac).
module ws_pe_dbuf import pe_pkg::*; #(
  parameter int DATA_WIDTH = PE_DATA_WIDTH,
  parameter int ACC_WIDTH  = PE_ACC_WIDTH,
  parameter int SIGNED     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_fmap,
  input  logic [ACC_WIDTH-1:0]  i_psum,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_weight,
  input  logic                  i_weight_valid,
  input  logic                  i_swap,
  output logic [DATA_WIDTH-1:0] o_fmap,
  output logic                  o_fmap_valid,
  output logic [ACC_WIDTH-1:0]  o_psum,
  output logic                  o_psum_valid,
  output logic [DATA_WIDTH-1:0] o_weight,
  output logic                  o_weight_valid,
  output logic                  o_swap
);
  logic [DATA_WIDTH-1:0] r_fmap, r_active, r_shadow;
  logic [ACC_WIDTH-1:0]  r_psum, mac_sum;
  logic                  r_fmap_vld, r_psum_vld, r_wgt_vld, r_swap;

  pe_mac #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH), .SIGNED(SIGNED)) u_mac (
    .fmap   (i_fmap),
    .weight (r_active),
    .psum   (i_psum),
    .sum    (mac_sum)
  );

  // MAC reads r_active before a coincident swap lands, and the swap takes
  // r_shadow before a coincident shift lands, so tiles stream without bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fmap     <= '0;
      r_psum     <= '0;
      r_active   <= '0;
      r_shadow   <= '0;
      r_fmap_vld <= 1'b0;
      r_psum_vld <= 1'b0;
      r_wgt_vld  <= 1'b0;
      r_swap     <= 1'b0;
    end else begin
      r_fmap_vld <= i_valid;
      r_psum_vld <= i_valid;
      r_wgt_vld  <= i_weight_valid;
      r_swap     <= i_swap;
      if (i_valid) begin
        r_fmap <= i_fmap;
        r_psum <= mac_sum;
      end
      if (i_weight_valid) r_shadow <= i_weight;
      if (i_swap)         r_active <= r_shadow;
    end
  end

  assign o_fmap         = r_fmap;
  assign o_fmap_valid   = r_fmap_vld;
  assign o_psum         = r_psum;
  assign o_psum_valid   = r_psum_vld;
  assign o_weight       = r_shadow;
  assign o_weight_valid = r_wgt_vld;
  assign o_swap         = r_swap;
endmodule
